// File: rtl/pipe_hazard_unit_if.sv
// ID-stage hazard/forwarding bundle: decoded operands and results in, operand selects and stall/bubble out.
// master = pipeline/ID side, slave = hazard unit.
interface pipe_hazard_unit_if #(
  parameter int SIZE  = 32,
  parameter int NREGS = 32,
  parameter int DEPTH = 3
);
  localparam int AW = $clog2(NREGS);
  localparam int FW = $clog2(DEPTH + 1);

  logic                  id_valid;
  logic [AW-1:0]         id_rs;
  logic                  id_rs_en;
  logic [AW-1:0]         id_rt;
  logic                  id_rt_en;
  logic [AW-1:0]         id_rd;
  logic                  id_wen;
  logic                  id_load;
  logic [SIZE-1:0]       rf_data_a;
  logic [SIZE-1:0]       rf_data_b;
  logic [DEPTH*SIZE-1:0] stage_data;
  logic                  stall;
  logic                  bubble;
  logic [SIZE-1:0]       opa;
  logic [SIZE-1:0]       opb;
  logic [FW-1:0]         fwd_a;
  logic [FW-1:0]         fwd_b;
  logic [15:0]           stall_count;

  modport master (
    output id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_wen, id_load,
    output rf_data_a, rf_data_b, stage_data,
    input  stall, bubble, opa, opb, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rs_en, id_rt, id_rt_en, id_rd, id_wen, id_load,
    input  rf_data_a, rf_data_b, stage_data,
    output stall, bubble, opa, opb, fwd_a, fwd_b, stall_count
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based RAW hazard/forwarding for the ID stage; resolution is combinational (0 cycles), stall freezes IF/ID and bubbles EX.
// Define HAZARD_FWD_EN for forwarding; without it every RAW match stalls until the producer retires.
module pipe_hazard_unit #(
  parameter int SIZE       = 32,
  parameter int NREGS      = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_unit_if.slave hif
);
  localparam int AW = $clog2(NREGS);
  localparam int FW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] sb_valid_q, sb_valid_d;
  logic [DEPTH-1:0] sb_load_q, sb_load_d;
  logic [AW-1:0]    sb_rd_q [DEPTH];
  logic [AW-1:0]    sb_rd_d [DEPTH];
  logic [15:0]      stall_count_q, stall_count_d;

  logic [DEPTH-1:0] match_a, match_b;
  logic             hazard_a, hazard_b, stall;
  logic [FW-1:0]    fwd_a, fwd_b;
  logic [SIZE-1:0]  opa, opb;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      match_a[k] = hif.id_rs_en && (hif.id_rs != '0) && sb_valid_q[k] && (sb_rd_q[k] == hif.id_rs);
      match_b[k] = hif.id_rt_en && (hif.id_rt != '0) && sb_valid_q[k] && (sb_rd_q[k] == hif.id_rt);
    end
  end

`ifdef HAZARD_FWD_EN
  logic [DEPTH-1:0] entry_rdy;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entry_rdy[k] = !sb_load_q[k] || (k >= LOAD_STAGE);
    end
  end

  // Walk oldest to youngest so the youngest matching entry is the one that sticks.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    fwd_a    = '0;
    fwd_b    = '0;
    opa      = hif.rf_data_a;
    opb      = hif.rf_data_b;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) begin
        hazard_a = !entry_rdy[k];
        fwd_a    = entry_rdy[k] ? FW'(k + 1) : '0;
        opa      = entry_rdy[k] ? hif.stage_data[k*SIZE +: SIZE] : hif.rf_data_a;
      end
      if (match_b[k]) begin
        hazard_b = !entry_rdy[k];
        fwd_b    = entry_rdy[k] ? FW'(k + 1) : '0;
        opb      = entry_rdy[k] ? hif.stage_data[k*SIZE +: SIZE] : hif.rf_data_b;
      end
    end
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{hif.stage_data, sb_load_q};

  always_comb begin
    hazard_a = |match_a;
    hazard_b = |match_b;
    fwd_a    = '0;
    fwd_b    = '0;
    opa      = hif.rf_data_a;
    opb      = hif.rf_data_b;
  end
`endif

  assign stall = hif.id_valid && (hazard_a || hazard_b);

  // A stalled ID instruction must not enter the scoreboard; entry 0 becomes the bubble.
  always_comb begin
    sb_valid_d[0] = hif.id_valid && !stall && hif.id_wen && (hif.id_rd != '0);
    sb_rd_d[0]    = hif.id_rd;
    sb_load_d[0]  = hif.id_load;
    for (int k = 1; k < DEPTH; k++) begin
      sb_valid_d[k] = sb_valid_q[k-1];
      sb_rd_d[k]    = sb_rd_q[k-1];
      sb_load_d[k]  = sb_load_q[k-1];
    end
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid_q    <= '0;
      sb_load_q     <= '0;
      stall_count_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        sb_rd_q[k] <= '0;
      end
    end else begin
      sb_valid_q    <= sb_valid_d;
      sb_load_q     <= sb_load_d;
      sb_rd_q       <= sb_rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hif.stall       = stall;
  assign hif.bubble      = stall;
  assign hif.fwd_a       = fwd_a;
  assign hif.fwd_b       = fwd_b;
  assign hif.opa         = opa;
  assign hif.opb         = opb;
  assign hif.stall_count = stall_count_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with an issue-history model checked every cycle; expectations follow HAZARD_FWD_EN.
module tb_pipe_hazard_unit;
  localparam int SIZE = 32;
  localparam int DEPTH = 3;
  localparam int LOAD_STAGE = 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [31:0] RF_A = 32'hAAAA_0000;
  localparam logic [31:0] RF_B = 32'h5555_0000;
  localparam logic [31:0] SD0  = 32'h0000_1234;
  localparam logic [31:0] SD1  = 32'hBBBB_0001;
  localparam logic [31:0] SD2  = 32'hCCCC_0002;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_unit_if #(.SIZE(SIZE), .NREGS(32), .DEPTH(DEPTH)) hif ();

  pipe_hazard_unit #(.SIZE(SIZE), .NREGS(32), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hif  (hif.slave)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: list of issued writers tagged with the cycle they left ID; age = cycles since issue.
  typedef struct {
    int issue;
    int rd;
    bit load;
  } rec_t;
  rec_t recs[$];
  int   cyc = 0;
  int   m_cnt = 0;
  bit   exp_stall = 1'b0;

  function automatic void eval(input bit en, input int r, output bit haz, output int fwd);
    int best = -1;
    bit ld = 1'b0;
    haz = 1'b0;
    fwd = 0;
    if (en && r != 0) begin
      foreach (recs[i]) begin
        int age = cyc - recs[i].issue;
        if (age < DEPTH && recs[i].rd == r && (best < 0 || age < best)) begin
          best = age;
          ld = recs[i].load;
        end
      end
    end
    if (best >= 0) begin
      if (FWD && (!ld || best >= LOAD_STAGE)) fwd = best + 1;
      else haz = 1'b1;
    end
  endfunction

  always @(negedge rst_n) begin
    recs.delete();
    m_cnt = 0;
    exp_stall = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      cyc++;
      if (exp_stall && m_cnt < 65535) m_cnt++;
      if (hif.id_valid && !exp_stall && hif.id_wen && hif.id_rd != 0)
        recs.push_back('{cyc, int'(hif.id_rd), hif.id_load});
      while (recs.size() > 0 && cyc - recs[0].issue >= DEPTH) void'(recs.pop_front());
    end
  end

  always @(negedge clk) begin
    bit ha, hb;
    int fa, fb;
    logic [DEPTH*SIZE-1:0] sd;
    sd = hif.stage_data;
    eval(hif.id_rs_en, int'(hif.id_rs), ha, fa);
    eval(hif.id_rt_en, int'(hif.id_rt), hb, fb);
    exp_stall = hif.id_valid && (ha || hb);
    check("m_stall", hif.stall, exp_stall);
    check("m_bubble", hif.bubble, exp_stall);
    check("m_fwd_a", hif.fwd_a, fa);
    check("m_fwd_b", hif.fwd_b, fb);
    check("m_stall_count", hif.stall_count, m_cnt);
    if (!ha) check("m_opa", hif.opa, (fa > 0) ? sd[(fa-1)*SIZE +: SIZE] : hif.rf_data_a);
    if (!hb) check("m_opb", hif.opb, (fb > 0) ? sd[(fb-1)*SIZE +: SIZE] : hif.rf_data_b);
  end

  task automatic drive(input bit v, input int rs, input bit rs_en, input int rt, input bit rt_en,
                       input int rd, input bit wen, input bit ld);
    @(posedge clk);
    #1;
    hif.id_valid = v;
    hif.id_rs    = 5'(rs);
    hif.id_rs_en = rs_en;
    hif.id_rt    = 5'(rt);
    hif.id_rt_en = rt_en;
    hif.id_rd    = 5'(rd);
    hif.id_wen   = wen;
    hif.id_load  = ld;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Hold the current ID instruction until it is no longer stalled; returns stalled cycles.
  task automatic hold(output int n);
    n = 0;
    while (hif.stall === 1'b1 && n < 10) begin
      n++;
      @(posedge clk);
      settle();
    end
    check("hold_bound", (n < 10), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    hif.id_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hif.id_valid = 1'b0; hif.id_rs = '0; hif.id_rs_en = 1'b0; hif.id_rt = '0; hif.id_rt_en = 1'b0;
    hif.id_rd = '0; hif.id_wen = 1'b0; hif.id_load = 1'b0;
    hif.rf_data_a = RF_A; hif.rf_data_b = RF_B;
    hif.stage_data = {SD2, SD1, SD0};

    // Reset state
    repeat (2) @(posedge clk);
    settle();
    check("rst_stall", hif.stall, 0);
    check("rst_bubble", hif.bubble, 0);
    check("rst_fwd_a", hif.fwd_a, 0);
    check("rst_opa", hif.opa, RF_A);
    check("rst_count", hif.stall_count, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: add r3 ; sub r6,r3,r2
    drive(1, 1, 1, 2, 1, 3, 1, 0); settle(); hold(n);
    drive(1, 3, 1, 2, 1, 6, 1, 0); settle();
    check("t1_stall", hif.stall, FWD ? 0 : 1);
    hold(n);
    check("t1_nstall", n, FWD ? 0 : 3);
    check("t1_fwd_a", hif.fwd_a, FWD ? 1 : 0);
    check("t1_opa", hif.opa, FWD ? SD0 : RF_A);
    check("t1_count", hif.stall_count, FWD ? 0 : 3);

    // 2: lw r4 ; add r5,r4,r1
    do_reset();
    drive(1, 0, 0, 0, 0, 4, 1, 1); settle(); hold(n);
    drive(1, 4, 1, 1, 1, 5, 1, 0); settle();
    check("t2_stall", hif.stall, 1);
    check("t2_bubble", hif.bubble, 1);
    hold(n);
    check("t2_nstall", n, FWD ? 1 : 3);
    check("t2_fwd_a", hif.fwd_a, FWD ? 2 : 0);
    check("t2_opa", hif.opa, FWD ? SD1 : RF_A);
    check("t2_count", hif.stall_count, FWD ? 1 : 3);

    // 5: lw r8 ; consumer of r8, reset while stalled
    drive(1, 0, 0, 0, 0, 8, 1, 1); settle(); hold(n);
    drive(1, 8, 1, 0, 0, 9, 1, 0); settle();
    check("t5_stall_pre", hif.stall, 1);
    check("t5_count_pre", hif.stall_count, FWD ? 1 : 3);
    #1; rst_n = 1'b0; #1;
    check("t5_stall_rst", hif.stall, 0);
    check("t5_bubble_rst", hif.bubble, 0);
    check("t5_count_rst", hif.stall_count, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    settle();
    check("t5_stall_post", hif.stall, 0);
    check("t5_fwd_post", hif.fwd_a, 0);

    // 3: r5 in entries 0 and 2, consumer reads r5 on B
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0); settle(); hold(n);
    drive(1, 0, 0, 0, 0, 7, 1, 0); settle(); hold(n);
    drive(1, 0, 0, 0, 0, 5, 1, 0); settle(); hold(n);
    drive(1, 0, 0, 5, 1, 9, 1, 0); settle();
    check("t3_stall", hif.stall, FWD ? 0 : 1);
    check("t3_fwd_b", hif.fwd_b, FWD ? 1 : 0);
    check("t3_opb", hif.opb, FWD ? SD0 : RF_B);
    hold(n);
    check("t3_nstall", n, FWD ? 0 : 3);

    // 4: producer of r0 ; consumer of r0
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1, 0); settle(); hold(n);
    drive(1, 0, 1, 0, 1, 6, 1, 0); settle();
    check("t4_stall", hif.stall, 0);
    check("t4_fwd_a", hif.fwd_a, 0);
    check("t4_fwd_b", hif.fwd_b, 0);
    check("t4_opa", hif.opa, RF_A);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
